// File: rtl/apb_rr_pkg.sv
// rtl/apb_rr_pkg.sv - shared state type, PSEL slot field and sizing constants for apb_rr_master
package apb_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int SLOT_LSB = 24;
    localparam int SLOT_W   = 4;
    localparam int NSLOT    = 16;
    localparam int NREQ_MAX = 8;
    localparam int PTR_W    = 3;

    function automatic logic [NSLOT-1:0] psel_decode(input logic [SLOT_W-1:0] slot);
        psel_decode = NSLOT'(1) << slot;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin pick starting after the last served requester
module apb_rr_arbiter
    import apb_rr_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [NREQ-1:0]  i_mask,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    logic [NREQ-1:0] w_elig;
    int              w_best;
    int              w_dist;

    always_comb begin
        w_elig = i_req & ~i_mask;
        w_best = NREQ;
        w_dist = 0;
        o_idx  = '0;
        o_gnt  = '0;
        // distance 0 is the requester right after the pointer, so the smallest distance wins
        for (int j = 0; j < NREQ; j++) begin
            w_dist = (j - int'(i_ptr) - 1 + 2 * NREQ) % NREQ;
            if (w_elig[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = PTR_W'(j);
            end
        end
        o_valid = |w_elig;
        for (int j = 0; j < NREQ; j++) begin
            o_gnt[j] = o_valid && (o_idx == PTR_W'(j));
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - round-robin multi-requester APB master with PSEL decode and PREADY timeout
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                     PCLK,
    input  logic                     PRESETN,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ-1:0]          REQ_WRITE,
    input  logic [NREQ*ADDR_W-1:0]   REQ_ADDR,
    input  logic [NREQ*DATA_W-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]          GNT,
    output logic [NREQ-1:0]          DONE,
    output logic [DATA_W-1:0]        RSP_RDATA,
    output logic                     RSP_ERR,
    output logic                     BUSY,
    output logic [NSLOT-1:0]         PSEL,
    output logic [ADDR_W-1:0]        PADDR,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam logic [31:0] LAST_WAIT = 32'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [31:0]         r_wait;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_done;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_busy;
    logic [NSLOT-1:0]    r_psel;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_penable;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;

    logic [NREQ-1:0]     w_gnt;
    logic [PTR_W-1:0]    w_idx;
    logic                w_valid;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_write;
    logic                w_timeout;

    // the requester finishing this cycle is masked so it cannot be regranted on its own DONE
    apb_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (REQ),
        .i_mask  (r_done),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_write = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_gnt[j]) begin
                w_addr  = REQ_ADDR[j*ADDR_W +: ADDR_W];
                w_wdata = REQ_WDATA[j*DATA_W +: DATA_W];
                w_write = REQ_WRITE[j];
            end
        end
        w_timeout = (TIMEOUT != 0) && (r_wait == LAST_WAIT);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state   <= ST_IDLE;
            r_ptr     <= PTR_W'(NREQ - 1);
            r_wait    <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_psel    <= '0;
            r_paddr   <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
        end else begin
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state  <= ST_SETUP;
                        r_ptr    <= w_idx;
                        r_gnt    <= w_gnt;
                        r_busy   <= 1'b1;
                        r_psel   <= psel_decode(w_addr[SLOT_LSB +: SLOT_W]);
                        r_paddr  <= w_addr;
                        r_pwrite <= w_write;
                        r_pwdata <= w_wdata;
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                end
                ST_ACCESS: begin
                    // PREADY wins over a timeout landing in the same cycle
                    if (PREADY || w_timeout) begin
                        r_state   <= ST_IDLE;
                        r_done    <= r_gnt;
                        r_err     <= PREADY ? PSLVERR : 1'b1;
                        r_rdata   <= (PREADY && !r_pwrite) ? PRDATA : '0;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                    end else begin
                        r_wait <= r_wait + 32'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign GNT       = r_gnt;
    assign DONE      = r_done;
    assign RSP_RDATA = r_rdata;
    assign RSP_ERR   = r_err;
    assign BUSY      = r_busy;
    assign PSEL      = r_psel;
    assign PADDR     = r_paddr;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - self-checking bench for apb_rr_master
module tb_apb_rr_master;

    localparam int NREQ    = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                   PCLK;
    logic                   PRESETN;
    logic [NREQ-1:0]        REQ;
    logic [NREQ-1:0]        REQ_WRITE;
    logic [NREQ*ADDR_W-1:0] REQ_ADDR;
    logic [NREQ*DATA_W-1:0] REQ_WDATA;
    logic [NREQ-1:0]        GNT;
    logic [NREQ-1:0]        DONE;
    logic [DATA_W-1:0]      RSP_RDATA;
    logic                   RSP_ERR;
    logic                   BUSY;
    logic [15:0]            PSEL;
    logic [ADDR_W-1:0]      PADDR;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [DATA_W-1:0]      PWDATA;
    logic [DATA_W-1:0]      PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;

    int              n_cmp = 0;
    int              n_bad = 0;
    int              m_last;
    logic [NREQ-1:0] m_mask;

    apb_rr_master #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .GNT(GNT), .DONE(DONE), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY),
        .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psel"},    64'(PSEL), 64'd0);
        check({tag, "_paddr"},   64'(PADDR), 64'd0);
        check({tag, "_penable"}, 64'(PENABLE), 64'd0);
        check({tag, "_pwrite"},  64'(PWRITE), 64'd0);
        check({tag, "_pwdata"},  64'(PWDATA), 64'd0);
        check({tag, "_gnt"},     64'(GNT), 64'd0);
        check({tag, "_done"},    64'(DONE), 64'd0);
        check({tag, "_rdata"},   64'(RSP_RDATA), 64'd0);
        check({tag, "_err"},     64'(RSP_ERR), 64'd0);
        check({tag, "_busy"},    64'(BUSY), 64'd0);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        REQ_WRITE[i]          = wr;
        REQ_ADDR[i*32 +: 32]  = addr;
        REQ_WDATA[i*32 +: 32] = wdata;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] req, input logic [NREQ-1:0] mask, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(last + k) % NREQ] && !mask[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge PCLK);
            m_mask = '0;
            check("idle_busy", 64'(BUSY), 64'd0);
            check("idle_done", 64'(DONE), 64'd0);
            check("idle_psel", 64'(PSEL), 64'd0);
        end
    endtask

    // called at the negedge of an IDLE cycle with REQ already driven; returns at the DONE-cycle negedge
    task automatic serve(input int waits, input bit slverr, input logic [31:0] rdata,
                         input bit noise, output int owner);
        int                     w;
        int                     acc;
        logic [31:0]            a;
        logic [31:0]            d;
        logic                   wr;
        logic [NREQ-1:0]        oh;
        logic [15:0]            exp_psel;
        logic                   exp_err;
        logic [31:0]            exp_rd;
        logic [NREQ-1:0]        sv_write;
        logic [NREQ*32-1:0]     sv_addr;
        logic [NREQ*32-1:0]     sv_wdata;

        check("pre_busy", 64'(BUSY), 64'd0);
        check("pre_done", 64'(DONE), 64'(m_mask));
        w = rr_pick(REQ, m_mask, m_last);
        if (w < 0) begin
            $display("FAIL serve: no eligible requester in stimulus");
            $fatal(1);
        end
        a        = REQ_ADDR[w*32 +: 32];
        d        = REQ_WDATA[w*32 +: 32];
        wr       = REQ_WRITE[w];
        oh       = NREQ'(1) << w;
        exp_psel = 16'(1) << a[27:24];
        sv_write = REQ_WRITE;
        sv_addr  = REQ_ADDR;
        sv_wdata = REQ_WDATA;

        @(negedge PCLK);
        check("setup_gnt",     64'(GNT), 64'(oh));
        check("setup_busy",    64'(BUSY), 64'd1);
        check("setup_psel",    64'(PSEL), 64'(exp_psel));
        check("setup_penable", 64'(PENABLE), 64'd0);
        check("setup_paddr",   64'(PADDR), 64'(a));
        check("setup_pwrite",  64'(PWRITE), 64'(wr));
        check("setup_pwdata",  64'(PWDATA), 64'(d));
        check("setup_done",    64'(DONE), 64'd0);
        REQ_WRITE = NREQ'($urandom);
        REQ_ADDR  = {$urandom, $urandom, $urandom, $urandom};
        REQ_WDATA = {$urandom, $urandom, $urandom, $urandom};

        acc = 0;
        exp_err = 1'b0;
        exp_rd  = '0;
        while (1) begin
            @(negedge PCLK);
            check("acc_penable", 64'(PENABLE), 64'd1);
            check("acc_psel",    64'(PSEL), 64'(exp_psel));
            check("acc_gnt",     64'(GNT), 64'(oh));
            check("acc_paddr",   64'(PADDR), 64'(a));
            if (acc == waits) begin
                PREADY  = 1'b1;
                PSLVERR = slverr;
                PRDATA  = rdata;
                exp_err = slverr;
                exp_rd  = wr ? 32'd0 : rdata;
                break;
            end
            PREADY  = 1'b0;
            PSLVERR = noise;
            PRDATA  = $urandom;
            if (acc == TIMEOUT - 1) begin
                exp_err = 1'b1;
                exp_rd  = 32'd0;
                break;
            end
            acc++;
        end

        @(negedge PCLK);
        check("done_pulse",   64'(DONE), 64'(oh));
        check("done_err",     64'(RSP_ERR), 64'(exp_err));
        check("done_rdata",   64'(RSP_RDATA), 64'(exp_rd));
        check("done_busy",    64'(BUSY), 64'd0);
        check("done_psel",    64'(PSEL), 64'd0);
        check("done_penable", 64'(PENABLE), 64'd0);
        check("done_gnt",     64'(GNT), 64'd0);
        REQ_WRITE = sv_write;
        REQ_ADDR  = sv_addr;
        REQ_WDATA = sv_wdata;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        m_last = w;
        m_mask = oh;
        owner  = w;
    endtask

    initial begin
        int              o;
        int              wt;
        logic [NREQ-1:0] r;

        PRESETN   = 1'b0;
        REQ       = '0;
        REQ_WRITE = '0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        m_last    = NREQ - 1;
        m_mask    = '0;
        @(negedge PCLK);
        @(negedge PCLK);
        check_all_zero("reset");
        PRESETN = 1'b1;

        // all four held high: order 0,1,2,3,0,1 from reset
        for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom), $urandom, $urandom);
        REQ = 4'hF;
        for (int k = 0; k < 6; k++) begin
            serve($urandom_range(0, 2), 1'b0, $urandom, 1'b0, o);
            check("rr_order", 64'(o), 64'(k % NREQ));
        end
        REQ = '0;
        idle(1);

        set_req(0, 1'b1, 32'h0100_0010, 32'hDEADBEEF);
        REQ = 4'b0001;
        serve(0, 1'b0, $urandom, 1'b0, o);
        check("single_write_owner", 64'(o), 64'd0);
        REQ = '0;
        idle(1);

        set_req(2, 1'b0, 32'h0300_0004, $urandom);
        REQ = 4'b0100;
        serve(3, 1'b0, 32'h12345678, 1'b0, o);
        check("read_owner", 64'(o), 64'd2);
        REQ = '0;
        idle(1);

        // stuck PREADY aborts; ready on the 8th cycle completes normally
        set_req(1, 1'b0, 32'h0500_0000, $urandom);
        REQ = 4'b0010;
        serve(TIMEOUT + 1, 1'b0, $urandom, 1'b0, o);
        REQ = '0;
        idle(1);
        REQ = 4'b0010;
        serve(TIMEOUT - 1, 1'b0, 32'hA5A5_0001, 1'b0, o);
        REQ = '0;
        idle(1);

        set_req(3, 1'b1, 32'h0F00_0100, 32'h0BAD_F00D);
        REQ = 4'b1000;
        serve(1, 1'b1, $urandom, 1'b0, o);
        REQ = '0;
        idle(1);
        set_req(3, 1'b0, 32'h0700_0200, $urandom);
        REQ = 4'b1000;
        serve(3, 1'b0, 32'h600D_CAFE, 1'b1, o);
        REQ = '0;
        idle(1);

        // reset mid-ACCESS kills the transfer without a DONE
        set_req(0, 1'b1, 32'h0200_0000, $urandom);
        REQ = 4'b0001;
        @(negedge PCLK);
        @(negedge PCLK);
        check("kill_in_access", 64'(PENABLE), 64'd1);
        #1 PRESETN = 1'b0;
        #1 check_all_zero("async_reset");
        set_req(1, 1'b0, 32'h0400_0008, $urandom);
        set_req(3, 1'b1, 32'h0800_000C, $urandom);
        REQ = 4'b1010;
        @(negedge PCLK);
        check_all_zero("in_reset");
        PRESETN = 1'b1;
        m_last = NREQ - 1;
        m_mask = '0;
        serve(0, 1'b0, $urandom, 1'b0, o);
        check("post_reset_first", 64'(o), 64'd1);
        REQ = 4'b1000;
        serve(1, 1'b0, $urandom, 1'b0, o);
        check("post_reset_second", 64'(o), 64'd3);
        REQ = '0;
        idle(1);

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom), $urandom, $urandom);
            do r = NREQ'($urandom_range(1, 15)); while ((r & ~m_mask) == '0);
            REQ = r;
            wt = ($urandom_range(0, 6) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 3));
            serve(wt, 1'($urandom), $urandom, 1'($urandom), o);
            if ($urandom_range(0, 3) == 0) begin
                REQ = '0;
                idle(int'($urandom_range(1, 2)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
